// File: rtl/apb_slave_regbank.sv
// Zero-wait-state APB slave with three one-hot selected register banks.
// Tracks SETUP/ACCESS phases and counts protocol/address violations.
module apb_slave_regbank #(
  parameter int DEPTH = 16,
  parameter int ERR_W = 8
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  input  logic             Pwrite,
  input  logic             Penable,
  input  logic [2:0]       Pselx,
  input  logic [31:0]      Paddr,
  input  logic [31:0]      Pwdata,
  output logic [31:0]      Prdata,
  input  logic             err_clr,
  output logic [15:0]      wr_count,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag
);
  localparam int AW    = $clog2(DEPTH);
  localparam int BANKS = 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cap_sel;
  logic [29:0]     cap_addr;
  logic            cap_write;

  logic            sel, acc, multi, oor, mism, viol, valid;
  logic [AW-1:0]   idx;
  logic [BANKS-1:0][31:0] rd_bank;

  assign sel   = |Pselx;
  assign acc   = sel & Penable;
  assign idx   = Paddr[2+AW-1:2];
  assign multi = (Pselx & (Pselx - 3'd1)) != 3'd0;
  assign oor   = |Paddr[31:2+AW];
  assign mism  = (Pselx != cap_sel) | (Paddr[31:2] != cap_addr) | (Pwrite != cap_write);
  // Any ACCESS not preceded by SETUP is flagged, plus the field checks; counted once.
  assign viol  = acc & ((state != SETUP) | mism | multi | oor);
  assign valid = acc & ~viol;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (sel) state_nxt = Penable ? ACCESS : SETUP;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      cap_sel   <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
    end else if (sel && !Penable) begin
      cap_sel   <= Pselx;
      cap_addr  <= Paddr[31:2];
      cap_write <= Pwrite;
    end
  end

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    logic [31:0] mem [DEPTH];

    always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (valid && Pwrite && Pselx[k]) begin
        mem[idx] <= Pwdata;
      end
    end

    assign rd_bank[k] = (valid && !Pwrite && Pselx[k]) ? mem[idx] : 32'd0;
  end

  always_comb begin
    Prdata = '0;
    for (int k = 0; k < BANKS; k++) Prdata = Prdata | rd_bank[k];
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn)             wr_count <= '0;
    else if (valid && Pwrite) wr_count <= wr_count + 16'd1;
  end

  // A violation in the same cycle as err_clr restarts the count at one.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (viol) begin
      err_flag <= 1'b1;
      if (err_clr)               err_count <= ERR_W'(1);
      else if (err_count != '1)  err_count <= err_count + ERR_W'(1);
    end else if (err_clr) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized scoreboard bench for apb_slave_regbank against an APB-rule reference model.
module tb_apb_slave_regbank;
  localparam int DEPTH = 16;
  localparam int ERR_W = 8;
  localparam int AW    = 4;

  logic        Hclk = 1'b0;
  logic        Hresetn, Pwrite, Penable, err_clr, err_flag;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic [15:0] wr_count;
  logic [ERR_W-1:0] err_count;

  apb_slave_regbank #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pwrite(Pwrite), .Penable(Penable),
    .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
    .err_clr(err_clr), .wr_count(wr_count), .err_count(err_count), .err_flag(err_flag)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [31:0] prdata;
    logic [15:0] wr;
    logic [ERR_W-1:0] err;
    logic        flag;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bus-level view of the slave
  logic [31:0] m_mem [3][DEPTH];
  bit          m_setup;
  logic [2:0]  c_sel;
  logic [31:0] c_addr;
  logic        c_w;
  int          m_wr, m_err;
  bit          m_flag;

  task automatic model_reset();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < DEPTH; i++) m_mem[b][i] = 32'd0;
    m_setup = 0; c_sel = 0; c_addr = 0; c_w = 0;
    m_wr = 0; m_err = 0; m_flag = 0;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Hclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("prdata",    Prdata,    e.prdata);
      check("wr_count",  wr_count,  e.wr);
      check("err_count", err_count, e.err);
      check("err_flag",  err_flag,  e.flag);
    end
  end

  task automatic cyc(input logic [2:0] ps, input logic [31:0] pa, input logic pw,
                     input logic pe, input logic [31:0] wd, input logic clr);
    bit sel, acc, bad;
    int b, idx;
    exp_t e;
    @(posedge Hclk); #1;
    Pselx = ps; Paddr = pa; Pwrite = pw; Penable = pe; Pwdata = wd; err_clr = clr;
    sel = (ps != 0);
    acc = sel && pe;
    bad = 0;
    if (acc)
      bad = !m_setup || ps != c_sel || pa[31:2] != c_addr[31:2] || pw != c_w ||
            $countones(ps) != 1 || (pa >> (2 + AW)) != 0;
    b   = ps[0] ? 0 : (ps[1] ? 1 : 2);
    idx = (pa >> 2) % DEPTH;
    e.prdata = (acc && !bad && !pw) ? m_mem[b][idx] : 32'd0;
    e.wr     = m_wr[15:0];
    e.err    = m_err[ERR_W-1:0];
    e.flag   = m_flag;
    exp_q.push_back(e);
    if (acc && !bad && pw) begin
      m_mem[b][idx] = wd;
      m_wr = (m_wr + 1) % 65536;
    end
    if (bad) begin
      m_flag = 1;
      m_err  = clr ? 1 : ((m_err < (1 << ERR_W) - 1) ? m_err + 1 : m_err);
    end else if (clr) begin
      m_flag = 0;
      m_err  = 0;
    end
    m_setup = sel && !pe;
    if (m_setup) begin c_sel = ps; c_addr = pa; c_w = pw; end
  endtask

  task automatic xfer(input logic [2:0] ps, input logic [31:0] pa, input logic pw,
                      input logic [31:0] wd);
    cyc(ps, pa, pw, 1'b0, wd, 1'b0);
    cyc(ps, pa, pw, 1'b1, wd, 1'b0);
  endtask

  task automatic idle(input logic clr);
    cyc(3'b000, 32'd0, 1'b0, 1'b0, 32'd0, clr);
  endtask

  task automatic reset_pulse();
    @(posedge Hclk); #1;
    Hresetn = 1'b0;
    Pselx = 0; Penable = 0; Pwrite = 0; Paddr = 0; Pwdata = 0; err_clr = 0;
    model_reset();
    repeat (2) @(posedge Hclk);
    #1 Hresetn = 1'b1;
  endtask

  logic [2:0] onehot [3] = '{3'b001, 3'b010, 3'b100};

  initial begin
    Hresetn = 1'b0; Pselx = 0; Penable = 0; Pwrite = 0; Paddr = 0; Pwdata = 0; err_clr = 0;
    model_reset();
    repeat (3) @(posedge Hclk);
    #1 Hresetn = 1'b1;

    // Reset reads
    idle(1'b0);
    xfer(3'b001, 32'h00, 1'b0, 0);
    xfer(3'b100, 32'h3C, 1'b0, 0);
    idle(1'b0);

    // Basic write/read
    xfer(3'b001, 32'h08, 1'b1, 32'hA5A5_0001);
    xfer(3'b001, 32'h08, 1'b0, 0);
    xfer(3'b010, 32'h08, 1'b0, 0);
    idle(1'b0);

    // Enable without setup
    cyc(3'b100, 32'h04, 1'b1, 1'b1, 32'h1234, 1'b0);
    idle(1'b0);
    xfer(3'b100, 32'h04, 1'b0, 0);

    // Address change between phases, then out of range
    cyc(3'b001, 32'h10, 1'b1, 1'b0, 32'hDEAD_0010, 1'b0);
    cyc(3'b001, 32'h14, 1'b1, 1'b1, 32'hDEAD_0010, 1'b0);
    xfer(3'b001, 32'h40, 1'b1, 32'hDEAD_0040);
    xfer(3'b001, 32'h10, 1'b0, 0);
    xfer(3'b001, 32'h14, 1'b0, 0);
    xfer(3'b001, 32'h00, 1'b0, 0);
    idle(1'b0);

    // Saturation and clear priority
    for (int i = 0; i < 300; i++) cyc(3'b100, 32'h04, 1'b1, 1'b1, i, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    cyc(3'b010, 32'h00, 1'b0, 1'b1, 0, 1'b1);
    idle(1'b0);

    // Back-to-back on bank1, then reset during SETUP
    xfer(3'b010, 32'h0C, 1'b1, 32'h1111_2222);
    xfer(3'b010, 32'h0C, 1'b0, 0);
    xfer(3'b010, 32'h3C, 1'b1, 32'h3333_4444);
    xfer(3'b010, 32'h3C, 1'b0, 0);
    cyc(3'b010, 32'h20, 1'b1, 1'b0, 32'h5555_6666, 1'b0);
    reset_pulse();
    idle(1'b0);
    xfer(3'b010, 32'h0C, 1'b0, 0);
    xfer(3'b010, 32'h3C, 1'b0, 0);
    xfer(3'b010, 32'h20, 1'b0, 0);
    xfer(3'b001, 32'h08, 1'b0, 0);
    xfer(3'b010, 32'h20, 1'b1, 32'h7777_8888);
    xfer(3'b010, 32'h20, 1'b0, 0);
    idle(1'b0);

    // Randomized traffic mixing legal transfers and violations
    for (int n = 0; n < 500; n++) begin
      int kind;
      logic [2:0]  ps;
      logic [31:0] pa, wd;
      logic        pw, clr;
      kind = $urandom_range(0, 11);
      ps   = onehot[$urandom_range(0, 2)];
      pa   = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
      pw   = $urandom_range(0, 1);
      wd   = $urandom;
      clr  = ($urandom_range(0, 15) == 0);
      case (kind)
        0, 1, 2, 3, 4, 5: begin
          cyc(ps, pa, pw, 1'b0, wd, 1'b0);
          cyc(ps, (pa & ~32'h3) | $urandom_range(0, 3), pw, 1'b1, wd, clr);
        end
        6: begin
          cyc(ps, pa, pw, 1'b0, wd, 1'b0);
          cyc(ps, pa ^ 32'h4, pw, 1'b1, wd, clr);
        end
        7:  cyc(ps, pa, pw, 1'b1, wd, clr);
        8:  xfer(ps, pa | (32'h1 << $urandom_range(2 + AW, 31)), pw, wd);
        9: begin
          cyc(3'b011 << $urandom_range(0, 1), pa, pw, 1'b0, wd, 1'b0);
          cyc(3'b011 << $urandom_range(0, 1), pa, pw, 1'b1, wd, clr);
        end
        10: begin
          cyc(ps, pa, pw, 1'b0, wd, 1'b0);
          cyc(ps, pa, ~pw, 1'b1, wd, clr);
        end
        default: idle(clr);
      endcase
    end
    idle(1'b0);

    repeat (3) @(posedge Hclk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
